// File: rtl/usb_nrzi_tx.sv
// USB-style serial transmitter: takes packet words over a valid/ready
// handshake, sends them LSB-first behind an optional SYNC field, inserts
// stuffed zeros, NRZI-codes the stream onto d_plus/d_minus and closes each
// packet with an SE0/J end-of-packet.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | line J, bit timer parked at 0, waiting for a word
// SYNC    | sending seven 0s then a 1 (line KJKJKJKK)
// DATA    | shifting out the current word, LSB first
// STUFF   | sending one inserted 0 after STUFF_LEN consecutive 1s
// EOP_SE0 | both lines low for EOP_SE0_BITS bit periods
// EOP_J   | one bit period of J before returning to IDLE

module usb_nrzi_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int SYNC_EN      = 1,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              busy,
    output logic              err_underrun,
    output logic              d_plus,
    output logic              d_minus
);

    localparam int TMR_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_W);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam int EOP_W  = $clog2(EOP_SE0_BITS + 1);

    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0]  TMR_PRE  = TMR_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);
    localparam logic [EOP_W-1:0]  EOP_LAST = EOP_W'(EOP_SE0_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        STUFF   = 3'd3,
        EOP_SE0 = 3'd4,
        EOP_J   = 3'd5
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [DATA_W-1:0] hold_data;
    logic              hold_last;
    logic              hold_full;
    logic [DATA_W-1:0] shifter;
    logic              cur_last;
    logic [IDX_W-1:0]  bit_idx;
    logic [2:0]        sync_cnt;
    logic [ONES_W-1:0] ones;
    logic [EOP_W-1:0]  eop_cnt;
    logic              line_j;

    logic              accept;
    logic              boundary;
    logic              bypass;
    logic              stuff_due;
    logic              word_end;
    logic              dp_step;
    logic              underrun_next;
    logic [DATA_W-1:0] start_data;
    logic              start_last;
    logic              step_to_stuff;
    logic              step_load;
    logic              step_eop;
    logic              launch_bit;
    logic              line_next;
    logic [ONES_W-1:0] ones_next;

    // Handshake, bit-boundary and underrun qualifiers.
    // err_underrun is registered, so it is decided one cycle ahead of the
    // boundary; the holding register can only fill (never drain) in that
    // cycle, so hold_full || accept is exactly its state at the boundary.
    always_comb begin
        tx_ready   = !hold_full &&
                     (state == IDLE || state == SYNC || state == DATA || state == STUFF);
        busy       = (state != IDLE);
        accept     = tx_valid && tx_ready;
        boundary   = (state != IDLE) && (timer == TMR_LAST);
        bypass     = (state == IDLE) && (SYNC_EN == 0) && !hold_full;
        stuff_due  = (ones == ONES_MAX);
        word_end   = (bit_idx == IDX_LAST);
        dp_step    = boundary &&
                     (state == DATA || state == STUFF || (state == SYNC && sync_cnt == 3'd7));
        start_data = hold_full ? hold_data : tx_data;
        start_last = hold_full ? hold_last : tx_last;
        underrun_next = (state == DATA || state == STUFF) && (timer == TMR_PRE) &&
                        !(state == DATA && stuff_due) && word_end && !cur_last &&
                        !hold_full && !accept;
    end

    // Choose the bit launched at the next boundary and its NRZI/ones effect.
    // After SYNC the shifter is marked as "word finished, not last" so the
    // first word is pulled from the holding register by the normal path.
    always_comb begin
        step_to_stuff = (state != STUFF) && stuff_due;
        step_load     = 1'b0;
        step_eop      = 1'b0;
        launch_bit    = 1'b0;
        if (!step_to_stuff) begin
            if (!word_end) begin
                launch_bit = shifter[1];
            end else if (!cur_last && hold_full) begin
                step_load  = 1'b1;
                launch_bit = hold_data[0];
            end else begin
                step_eop = 1'b1;
            end
        end
        if (state == IDLE) begin
            launch_bit = (SYNC_EN != 0) ? 1'b0 : start_data[0];
        end else if (state == SYNC && sync_cnt != 3'd7) begin
            launch_bit = (sync_cnt == 3'd6);
        end
        line_next = launch_bit ? line_j : !line_j;
        if (!launch_bit) begin
            ones_next = '0;
        end else if (stuff_due) begin
            ones_next = ONES_MAX;
        end else begin
            ones_next = ones + ONES_W'(1);
        end
    end

    // Transmit FSM: bit timer, line register, shifter and holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            hold_data    <= '0;
            hold_last    <= 1'b0;
            hold_full    <= 1'b0;
            shifter      <= '0;
            cur_last     <= 1'b0;
            bit_idx      <= '0;
            sync_cnt     <= '0;
            ones         <= '0;
            eop_cnt      <= '0;
            line_j       <= 1'b1;
            d_plus       <= 1'b1;
            d_minus      <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            err_underrun <= underrun_next;
            timer        <= (state == IDLE || boundary) ? '0 : timer + TMR_W'(1);

            case (state)
                IDLE: begin
                    line_j  <= 1'b1;
                    d_plus  <= 1'b1;
                    d_minus <= 1'b0;
                    if (hold_full || accept) begin
                        ones    <= ONES_W'(launch_bit);
                        line_j  <= line_next;
                        d_plus  <= line_next;
                        d_minus <= !line_next;
                        if (SYNC_EN != 0) begin
                            state    <= SYNC;
                            sync_cnt <= '0;
                            bit_idx  <= IDX_LAST;
                            cur_last <= 1'b0;
                        end else begin
                            state     <= DATA;
                            shifter   <= start_data;
                            cur_last  <= start_last;
                            bit_idx   <= '0;
                            hold_full <= 1'b0;
                        end
                    end
                end
                SYNC: begin
                    if (boundary && sync_cnt != 3'd7) begin
                        sync_cnt <= sync_cnt + 3'd1;
                        ones     <= ones_next;
                        line_j   <= line_next;
                        d_plus   <= line_next;
                        d_minus  <= !line_next;
                    end
                end
                EOP_SE0: begin
                    if (boundary) begin
                        if (eop_cnt == EOP_LAST) begin
                            state   <= EOP_J;
                            line_j  <= 1'b1;
                            d_plus  <= 1'b1;
                            d_minus <= 1'b0;
                        end else begin
                            eop_cnt <= eop_cnt + EOP_W'(1);
                        end
                    end
                end
                EOP_J: begin
                    if (boundary) begin
                        state <= IDLE;
                    end
                end
                DATA, STUFF: begin
                end
                default: state <= IDLE;
            endcase

            if (dp_step) begin
                if (step_eop) begin
                    state   <= EOP_SE0;
                    eop_cnt <= '0;
                    d_plus  <= 1'b0;
                    d_minus <= 1'b0;
                end else begin
                    state   <= step_to_stuff ? STUFF : DATA;
                    ones    <= ones_next;
                    line_j  <= line_next;
                    d_plus  <= line_next;
                    d_minus <= !line_next;
                    if (step_load) begin
                        shifter   <= hold_data;
                        cur_last  <= hold_last;
                        bit_idx   <= '0;
                        hold_full <= 1'b0;
                    end else if (!step_to_stuff) begin
                        shifter <= shifter >> 1;
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
            end

            if (accept && !bypass) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Directed bench for usb_nrzi_tx: default instance plus a fast, SYNC-less,
// short-stuff variant. Line symbols: J, K, 0 (SE0).
module tb_usb_nrzi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] tx_data1, tx_data2;
    logic       tx_valid1, tx_valid2, tx_last1, tx_last2;
    logic       tx_ready1, tx_ready2, busy1, busy2, err1, err2;
    logic       dp1, dm1, dp2, dm2;

    int  n_cmp = 0;
    int  n_bad = 0;
    byte obs [0:1023];
    int  nobs, nerr, err_at, acc_at, rdy_se0;
    bit  timed_out;
    logic end_dp, end_dm, end_rdy;

    usb_nrzi_tx u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_last(tx_last1), .tx_ready(tx_ready1), .busy(busy1),
        .err_underrun(err1), .d_plus(dp1), .d_minus(dm1)
    );

    usb_nrzi_tx #(.CLKS_PER_BIT(4), .SYNC_EN(0), .STUFF_LEN(3)) u_dut_v (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_last(tx_last2), .tx_ready(tx_ready2), .busy(busy2),
        .err_underrun(err2), .d_plus(dp2), .d_minus(dm2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic byte sym(input logic dp, input logic dm);
        if (dp === 1'b1 && dm === 1'b0) return "J";
        if (dp === 1'b0 && dm === 1'b1) return "K";
        if (dp === 1'b0 && dm === 1'b0) return "0";
        return "X";
    endfunction

    // First cycle where the captured line differs from the per-bit pattern, or -1.
    function automatic int line_diff(input string bits, input int cpb);
        int n = bits.len() * cpb;
        int m = (n > nobs) ? n : nobs;
        for (int i = 0; i < m; i++) begin
            if (i >= n || i >= nobs) return i;
            if (obs[i] != bits[i / cpb]) return i;
        end
        return -1;
    endfunction

    function automatic string obs_bits(input int cpb);
        string s = "";
        for (int k = 0; k * cpb < nobs; k++) s = $sformatf("%s%c", s, obs[k * cpb]);
        return s;
    endfunction

    // Drives up to two words, handshaking on tx_ready, and records the line
    // for every busy cycle until busy falls.
    task automatic run_pkt(input bit v2, input logic [7:0] w0, input logic [7:0] w1,
                           input int nwords, input bit mark_last);
        int idx = 0;
        bit started = 0;
        logic rdy, b, e, dp, dm;
        nobs = 0; nerr = 0; err_at = -1; acc_at = -1; rdy_se0 = 0; timed_out = 1;
        for (int c = 0; c < 600; c++) begin
            if (v2) begin
                tx_valid2 = (idx < nwords);
                tx_data2  = (idx == 0) ? w0 : w1;
                tx_last2  = mark_last && (idx == nwords - 1);
                rdy = tx_ready2;
            end else begin
                tx_valid1 = (idx < nwords);
                tx_data1  = (idx == 0) ? w0 : w1;
                tx_last1  = mark_last && (idx == nwords - 1);
                rdy = tx_ready1;
            end
            if (idx < nwords && rdy === 1'b1) begin
                if (idx == 1) acc_at = nobs - 1;
                idx++;
            end
            step();
            b   = v2 ? busy2 : busy1;
            e   = v2 ? err2 : err1;
            dp  = v2 ? dp2 : dp1;
            dm  = v2 ? dm2 : dm1;
            rdy = v2 ? tx_ready2 : tx_ready1;
            if (e === 1'b1) begin
                nerr++;
                err_at = nobs;
            end
            if (b === 1'b1) begin
                started = 1;
                if (nobs < 1024) obs[nobs] = sym(dp, dm);
                if (sym(dp, dm) == "0" && rdy === 1'b1) rdy_se0++;
                nobs++;
            end else if (started) begin
                end_dp = dp; end_dm = dm; end_rdy = rdy;
                timed_out = 0;
                break;
            end
        end
        tx_valid1 = 1'b0;
        tx_valid2 = 1'b0;
    endtask

    task automatic test_reset();
        int d;
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (dp1 !== 1'b1) begin n_bad++; $display("FAIL rst_dplus got %b want 1", dp1); end
        n_cmp++; if (dm1 !== 1'b0) begin n_bad++; $display("FAIL rst_dminus got %b want 0", dm1); end
        n_cmp++; if (tx_ready1 !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", tx_ready1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy1); end
        n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err1); end
        n_cmp++; if ({dp2, dm2, tx_ready2, busy2} !== 4'b1010) begin
            n_bad++; $display("FAIL rst_variant got %b want 1010", {dp2, dm2, tx_ready2, busy2});
        end
        rst = 1'b0;
        // start a packet, then reset it in the middle of the data phase
        tx_data1 = 8'h00; tx_last1 = 1'b1; tx_valid1 = 1'b1;
        step();
        tx_valid1 = 1'b0;
        repeat (80) step();
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", busy1); end
        rst = 1'b1;
        step();
        n_cmp++; if ({dp1, dm1} !== 2'b10) begin n_bad++; $display("FAIL mid_rst_line got %b want 10", {dp1, dm1}); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy1); end
        n_cmp++; if (tx_ready1 !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready got %b want 1", tx_ready1); end
        rst = 1'b0;
        run_pkt(1'b0, 8'h00, 8'h00, 1, 1'b1);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL post_rst_done got timeout want busy fall"); end
        d = line_diff("KJKJKJKKJKJKJKJK00J", 8);
        n_cmp++; if (d !== -1) begin
            n_bad++; $display("FAIL post_rst_line diff@%0d got %s want KJKJKJKKJKJKJKJK00J", d, obs_bits(8));
        end
    endtask

    task automatic test_single_zero();
        int d;
        run_pkt(1'b0, 8'h00, 8'h00, 1, 1'b1);
        d = line_diff("KJKJKJKKJKJKJKJK00J", 8);
        n_cmp++; if (d !== -1) begin
            n_bad++; $display("FAIL zero_line diff@%0d got %s want KJKJKJKKJKJKJKJK00J", d, obs_bits(8));
        end
        n_cmp++; if (nobs !== 152) begin n_bad++; $display("FAIL zero_busy got %0d want 152", nobs); end
        n_cmp++; if (nerr !== 0) begin n_bad++; $display("FAIL zero_err got %0d want 0", nerr); end
        n_cmp++; if (rdy_se0 !== 0) begin n_bad++; $display("FAIL zero_ready_in_eop got %0d want 0", rdy_se0); end
        n_cmp++; if ({end_dp, end_dm, end_rdy} !== 3'b101) begin
            n_bad++; $display("FAIL zero_idle got %b want 101", {end_dp, end_dm, end_rdy});
        end
    endtask

    task automatic test_stuff_ff();
        int d;
        run_pkt(1'b0, 8'hFF, 8'h00, 1, 1'b1);
        d = line_diff("KJKJKJKKKKKKKJJJJ00J", 8);
        n_cmp++; if (d !== -1) begin
            n_bad++; $display("FAIL ff_line diff@%0d got %s want KJKJKJKKKKKKKJJJJ00J", d, obs_bits(8));
        end
        n_cmp++; if (nobs !== 160) begin n_bad++; $display("FAIL ff_busy got %0d want 160", nobs); end
        n_cmp++; if (nerr !== 0) begin n_bad++; $display("FAIL ff_err got %0d want 0", nerr); end
    endtask

    task automatic test_back_to_back();
        int d;
        run_pkt(1'b0, 8'h3C, 8'hA5, 2, 1'b1);
        d = line_diff("KJKJKJKKJKKKKKJKKJJKJJKK00J", 8);
        n_cmp++; if (d !== -1) begin
            n_bad++; $display("FAIL b2b_line diff@%0d got %s want KJKJKJKKJKKKKKJKKJJKJJKK00J", d, obs_bits(8));
        end
        n_cmp++; if (nobs !== 216) begin n_bad++; $display("FAIL b2b_busy got %0d want 216", nobs); end
        n_cmp++; if (nerr !== 0) begin n_bad++; $display("FAIL b2b_err got %0d want 0", nerr); end
        n_cmp++; if (acc_at !== 64) begin n_bad++; $display("FAIL b2b_second_accept got %0d want 64", acc_at); end
    endtask

    task automatic test_underrun();
        int d;
        run_pkt(1'b0, 8'h12, 8'h00, 1, 1'b0);
        n_cmp++; if (nerr !== 1) begin n_bad++; $display("FAIL ur_pulses got %0d want 1", nerr); end
        n_cmp++; if (err_at !== 127) begin n_bad++; $display("FAIL ur_position got %0d want 127", err_at); end
        d = line_diff("KJKJKJKKJJKJJKJK00J", 8);
        n_cmp++; if (d !== -1) begin
            n_bad++; $display("FAIL ur_line diff@%0d got %s want KJKJKJKKJJKJJKJK00J", d, obs_bits(8));
        end
    endtask

    task automatic test_param_variant();
        int d;
        run_pkt(1'b1, 8'h0F, 8'h00, 1, 1'b1);
        d = line_diff("JJJKKJKJK00J", 4);
        n_cmp++; if (d !== -1) begin
            n_bad++; $display("FAIL var_line diff@%0d got %s want JJJKKJKJK00J", d, obs_bits(4));
        end
        n_cmp++; if (nobs !== 48) begin n_bad++; $display("FAIL var_busy got %0d want 48", nobs); end
        n_cmp++; if (nerr !== 0) begin n_bad++; $display("FAIL var_err got %0d want 0", nerr); end
    endtask

    initial begin
        rst = 1'b1;
        tx_data1 = '0; tx_valid1 = 1'b0; tx_last1 = 1'b0;
        tx_data2 = '0; tx_valid2 = 1'b0; tx_last2 = 1'b0;
        test_reset();
        test_single_zero();
        test_stuff_ff();
        test_back_to_back();
        test_underrun();
        test_param_variant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_nrzi_tx.md
Name: usb_nrzi_tx

Overview:
- Parametrised USB-style serial transmitter: accepts packet words over a valid/ready handshake and serialises them LSB-first.
- Adds an optional SYNC field, performs bit stuffing, NRZI-encodes the stream onto d_plus/d_minus, and terminates each packet with SE0/J EOP.
- Replaces the fixed 8-bit, fixed-rate transmit chain.
- Sits between the packet builder and the USB pad drivers.

Parameters:
- DATA_W, 8: bits per input word, transmitted LSB-first; must be ≥2.
- CLKS_PER_BIT, 8: clk cycles per line bit; must be ≥2.
- STUFF_LEN, 6: consecutive 1s after which a 0 is inserted; must be ≥1.
- SYNC_EN, 1: 1 = prepend SYNC; 0 = start directly with data.
- EOP_SE0_BITS, 2: SE0 duration of EOP in bit periods; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  DATA_W  word to send
- tx_valid  in  1  tx_data/tx_last valid
- tx_last  in  1  word is final word of the packet
- tx_ready  out  1  holding register can accept a word
- busy  out  1  packet in progress
- err_underrun  out  1  one-cycle pulse: data word needed but none held
- d_plus  out  1  line D+
- d_minus  out  1  line D-

Behaviour:
- Reset (rst high at a clk edge) overrides everything, including mid-packet. Next cycle: state IDLE, d_plus=1, d_minus=0 (J), tx_ready=1, busy=0, err_underrun=0. Holding register, shifter and all counters are cleared.
- Handshake:
  - A word (tx_data, tx_last) is accepted on any cycle where tx_valid && tx_ready.
  - The one-entry holding register sets on accept and clears when its contents move to the shifter.
  - tx_ready = holding empty AND state ∈ {IDLE, SYNC, DATA, STUFF}. Therefore tx_ready=0 in EOP_SE0 and EOP_J.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and is held at 0 in IDLE.
  - Bit boundary = the cycle where the count is CLKS_PER_BIT-1. The line changes only on the cycle after a boundary.
- States:
  - IDLE: line J. On an accept, go to SYNC (SYNC_EN=1) or DATA (SYNC_EN=0) on the next cycle. The first word moves to the shifter at entry to DATA. busy rises on the cycle after the accept.
  - SYNC: 8 bits, value 0000_0001 in transmit order (seven 0s then a 1), giving line pattern KJKJKJKK. The ones counter resets at SYNC entry and counts SYNC's final 1.
  - DATA: shift out DATA_W bits.
    - After the last bit of a word: if that word had tx_last, go to EOP_SE0.
    - Else, if the holding register is full, load it into the shifter with no gap.
    - Else pulse err_underrun for 1 cycle at that boundary and go to EOP_SE0.
  - STUFF: entered at the boundary where the ones counter reaches STUFF_LEN. Transmits one 0 bit, resets the ones counter, then resumes DATA where it left off. This also applies after the final bit of the last word: the stuff bit is sent before EOP.
  - EOP_SE0: d_plus=d_minus=0 for EOP_SE0_BITS bit periods.
  - EOP_J: J for 1 bit period, then IDLE. busy falls on entry to IDLE. A word already accepted in IDLE starts the next packet.
- NRZI: bit 0 toggles the line between J (1,0) and K (0,1); bit 1 holds it. The NRZI state is forced to J in IDLE and at EOP exit.
- Ones counter: width clog2(STUFF_LEN+1). Increments on every transmitted 1 (SYNC and DATA), clears on every 0 including stuffed 0s, and saturates at STUFF_LEN.
- Widths: bit index clog2(DATA_W); timer clog2(CLKS_PER_BIT); EOP counter clog2(EOP_SE0_BITS+1).
- Simultaneous events: an accept on the same cycle the holding register empties into the shifter is legal and keeps the register full. An underrun pulse and EOP entry occur on the same boundary.

Test Plan:
All cases use default parameters unless stated.
1. Reset: hold rst 2 cycles → d_plus=1, d_minus=0, tx_ready=1, busy=0, err_underrun=0. Assert rst mid-DATA → next cycle J, busy=0, tx_ready=1. A packet started immediately afterwards completes normally.
2. Single word 0x00, tx_last=1:
   - Line sequence: KJKJKJKK, then 8 alternating bits starting J, then SE0 for 16 cycles, then J for 8 cycles.
   - busy high for exactly 19×8=152 cycles.
3. Single word 0xFF, tx_last=1:
   - A stuffed 0 (line toggle) appears after the 5th data 1, because SYNC's final 1 counts toward the six.
   - 9 data-phase bits; busy = 20×8 = 160 cycles.
4. Back-to-back words 0x3C, 0xA5, tx_valid held high, tx_last on the second word:
   - Second word accepted during the first word.
   - No gap between words, no err_underrun.
   - busy = (8+16+3)×8 = 216 cycles.
5. Underrun: word 0x12 with tx_last=0, then tx_valid=0 → err_underrun high for exactly 1 cycle at the boundary after bit 7; SE0 starts on the following cycle.
6. Parameter variant CLKS_PER_BIT=4, SYNC_EN=0, STUFF_LEN=3, word 0x0F last → first data bit is at the cycle after accept. A stuffed 0 follows the 3rd 1. busy = (9+2+1)×4 = 48 cycles.
